// File: rtl/aes_inv_key_expand_128.sv
// Reverse AES-128 key schedule for the decrypt path.
// Loads the round-NR key and walks the schedule backwards, presenting
// round keys NR..0 on a valid/ready interface, one per accepted transfer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no sequence in flight; ld starts a new one
// RUN   | kr holds round key kr_round; advance to kr_round-1 on accept

// Combinational AES forward S-box (table lookup).
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign d = SBOX[a];
endmodule

module aes_inv_key_expand_128 #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ld,
    input  logic [127:0] key_in,
    output logic [127:0] kr,
    output logic [3:0]   kr_round,
    output logic         kr_valid,
    input  logic         kr_ready,
    output logic         busy,
    output logic         done
);
    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   kr_q, kr_d;
    logic [3:0]     round_q, round_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    p0, p1, p2, p3;
    logic [31:0]    rot_w, sub_w;
    logic [127:0]   prev_key;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    assign w0 = kr_q[127:96];
    assign w1 = kr_q[95:64];
    assign w2 = kr_q[63:32];
    assign w3 = kr_q[31:0];

    // Undo the forward XOR chain; p3 is the recovered previous w3,
    // which is what the forward schedule fed through RotWord/SubWord.
    assign p3    = w3 ^ w2;
    assign p2    = w2 ^ w1;
    assign p1    = w1 ^ w0;
    assign rot_w = {p3[23:0], p3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .a (rot_w[8*i +: 8]),
            .d (sub_w[8*i +: 8])
        );
    end

    // rcon index is round_q, only consumed when round_q is 1..NR.
    assign p0       = w0 ^ sub_w ^ {rcon(round_q), 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            kr_q    <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kr_q    <= kr_d;
            round_q <= round_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load in IDLE, step one round per accepted transfer in RUN.
    always_comb begin
        state_d = state_q;
        kr_d    = kr_q;
        round_d = round_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld) begin
                    state_d = RUN;
                    kr_d    = key_in;
                    round_d = NR_L;
                    valid_d = 1'b1;
                end
            end
            RUN: begin
                if (kr_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        kr_d    = prev_key;
                        round_d = round_q - 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign kr       = kr_q;
    assign kr_round = round_q;
    assign kr_valid = valid_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;
endmodule
